// File: rtl/afifo_rd_stream.sv
// Async-FIFO read side to valid/ready stream adapter.
// Prefetches into a small skid buffer so m_data/m_valid come from registers.
module afifo_rd_stream #(
  parameter int DSIZE      = 8,
  parameter int RD_LATENCY = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [DSIZE-1:0]     fifo_rdata,
  input  logic                 fifo_rempty,
  output logic                 fifo_rinc,
  input  logic                 flush,
  output logic [DSIZE-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int BUF_DEPTH = 2 + RD_LATENCY;

  logic [DSIZE-1:0]     slot_q [BUF_DEPTH];
  logic [DSIZE-1:0]     slot_d [BUF_DEPTH];
  logic [1:0]           occ_q;
  logic [1:0]           occ_d;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [1:0]           inflight;
  logic [1:0]           wr_idx;
  logic [2:0]           level;
  logic                 push;
  logic                 pop;

  // Each issued read is tracked so the buffer never overcommits.
  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign inflight = 2'd0;
      assign push     = fifo_rinc;
    end else begin : g_latn
      logic [RD_LATENCY-1:0] pipe_q;

      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          pipe_q <= '0;
        end else if (flush) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= (pipe_q << 1) | RD_LATENCY'(fifo_rinc);
        end
      end

      assign inflight = 2'($countones(pipe_q));
      assign push     = pipe_q[RD_LATENCY-1];
    end
  endgenerate

  assign level     = {1'b0, occ_q} + {1'b0, inflight};
  assign fifo_rinc = rrst_n && !fifo_rempty && !flush
                     && (level < 3'(BUF_DEPTH));
  assign pop       = valid_q && m_ready;
  assign wr_idx    = occ_q - 2'(pop);

  always_comb begin
    slot_d = slot_q;
    occ_d  = occ_q + 2'(push) - 2'(pop);
    if (pop) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        slot_d[i] = slot_q[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (2'(i) == wr_idx) slot_d[i] = fifo_rdata;
      end
    end
    // Flush drops buffered words and any word landing this edge.
    if (flush) occ_d = 2'd0;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) slot_q[i] <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != 2'd0);
      if (pop) cnt_q <= cnt_q + 1'b1;
    end
  end

  a_no_overflow : assert property (
    @(posedge rclk) disable iff (!rrst_n)
    !(push && !flush && occ_q == 2'(BUF_DEPTH) && !pop)
  );

  assign m_data    = slot_q[0];
  assign m_valid   = valid_q;
  assign occupancy = occ_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream: latency 0 and latency 1 instances
// each fed by a small behavioural FIFO read port.
module tb_afifo_rd_stream;

  logic        clk;
  logic        run;
  logic        rrst_n;

  logic [7:0]  rdata0, mdata0;
  logic        rempty0, rinc0, flush0, mvalid0, mready0;
  logic [1:0]  occ0;
  logic [3:0]  cnt0;

  logic [7:0]  rdata1, mdata1;
  logic        rempty1, rinc1, flush1, mvalid1, mready1;
  logic [1:0]  occ1;
  logic [15:0] cnt1;

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  logic [7:0]  rp0, wp0, rp1, wp1;

  int checks;
  int failures;

  afifo_rd_stream #(.DSIZE(8), .RD_LATENCY(0), .CNT_WIDTH(4)) u0 (
    .rclk(clk), .rrst_n(rrst_n), .fifo_rdata(rdata0),
    .fifo_rempty(rempty0), .fifo_rinc(rinc0), .flush(flush0),
    .m_data(mdata0), .m_valid(mvalid0), .m_ready(mready0),
    .occupancy(occ0), .word_cnt(cnt0)
  );

  afifo_rd_stream #(.DSIZE(8), .RD_LATENCY(1), .CNT_WIDTH(16)) u1 (
    .rclk(clk), .rrst_n(rrst_n), .fifo_rdata(rdata1),
    .fifo_rempty(rempty1), .fifo_rinc(rinc1), .flush(flush1),
    .m_data(mdata1), .m_valid(mvalid1), .m_ready(mready1),
    .occupancy(occ1), .word_cnt(cnt1)
  );

  // FIFO read ports: show-ahead for u0, one-cycle registered for u1.
  assign rempty0 = (rp0 == wp0);
  assign rdata0  = mem0[rp0];
  assign rempty1 = (rp1 == wp1);

  always @(posedge clk) if (rinc0) rp0 <= rp0 + 8'd1;

  always @(posedge clk) begin
    if (rinc1) begin
      rdata1 <= mem1[rp1];
      rp1    <= rp1 + 8'd1;
    end
  end

  initial clk = 1'b0;
  always #5 if (run) clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put0(input logic [7:0] d);
    mem0[wp0] = d;
    wp0 = wp0 + 8'd1;
  endtask

  task automatic put1(input logic [7:0] d);
    mem1[wp1] = d;
    wp1 = wp1 + 8'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    run = 1'b1;
    rrst_n = 1'b0;
    rp0 = 8'd0; wp0 = 8'd0; rp1 = 8'd0; wp1 = 8'd0;
    rdata1 = 8'd0;
    flush0 = 1'b0; flush1 = 1'b0;
    mready0 = 1'b1; mready1 = 1'b1;

    // Reset with FIFO 0 already non-empty
    put0(8'h11); put0(8'h22); put0(8'h33);
    tick; tick;
    chk("rst_valid0", 32'(mvalid0), 32'd0);
    chk("rst_data0", 32'(mdata0), 32'd0);
    chk("rst_occ0", 32'(occ0), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_rinc0", 32'(rinc0), 32'd0);
    chk("rst_valid1", 32'(mvalid1), 32'd0);

    // Three words at latency 0
    rrst_n = 1'b1;
    #1;
    chk("a_rinc_rel", 32'(rinc0), 32'd1);
    chk("a_rinc1_idle", 32'(rinc1), 32'd0);
    tick;
    chk("a_valid1", 32'(mvalid0), 32'd1);
    chk("a_data1", 32'(mdata0), 32'h11);
    chk("a_rinc1", 32'(rinc0), 32'd1);
    tick;
    chk("a_data2", 32'(mdata0), 32'h22);
    chk("a_rinc2", 32'(rinc0), 32'd1);
    tick;
    chk("a_data3", 32'(mdata0), 32'h33);
    chk("a_rinc3", 32'(rinc0), 32'd0);
    tick;
    chk("a_valid_end", 32'(mvalid0), 32'd0);
    chk("a_cnt", 32'(cnt0), 32'd3);
    chk("a_rinc4", 32'(rinc0), 32'd0);

    // Ten words at latency 1
    for (int i = 0; i < 10; i++) put1(8'hA0 + 8'(i));
    #1;
    chk("b_rinc0", 32'(rinc1), 32'd1);
    tick;
    chk("b_valid_f1", 32'(mvalid1), 32'd0);
    chk("b_rinc_f1", 32'(rinc1), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("b_valid", 32'(mvalid1), 32'd1);
      chk("b_data", 32'(mdata1), 32'hA0 + 32'(k));
    end
    tick;
    chk("b_valid_end", 32'(mvalid1), 32'd0);
    chk("b_cnt", 32'(cnt1), 32'd10);

    // Backpressure at latency 0
    mready0 = 1'b0;
    put0(8'h51); put0(8'h52); put0(8'h53); put0(8'h54);
    tick; tick;
    chk("c_occ_full", 32'(occ0), 32'd2);
    chk("c_rinc_full", 32'(rinc0), 32'd0);
    chk("c_data_hold", 32'(mdata0), 32'h51);
    tick; tick;
    chk("c_occ_hold", 32'(occ0), 32'd2);
    chk("c_data_hold2", 32'(mdata0), 32'h51);
    chk("c_rinc_hold", 32'(rinc0), 32'd0);
    mready0 = 1'b1;
    tick;
    chk("c_data52", 32'(mdata0), 32'h52);
    chk("c_occ1", 32'(occ0), 32'd1);
    tick;
    chk("c_data53", 32'(mdata0), 32'h53);
    tick;
    chk("c_data54", 32'(mdata0), 32'h54);
    chk("c_rinc_empty", 32'(rinc0), 32'd0);
    tick;
    chk("c_valid_end", 32'(mvalid0), 32'd0);
    chk("c_cnt", 32'(cnt0), 32'd7);

    // Flush coinciding with a pop still counts
    mready0 = 1'b0;
    put0(8'h61); put0(8'h62);
    tick; tick;
    chk("d_occ", 32'(occ0), 32'd2);
    flush0 = 1'b1;
    mready0 = 1'b1;
    #1;
    chk("d_rinc_flush", 32'(rinc0), 32'd0);
    tick;
    chk("d_valid", 32'(mvalid0), 32'd0);
    chk("d_occ0", 32'(occ0), 32'd0);
    chk("d_cnt", 32'(cnt0), 32'd8);
    flush0 = 1'b0;

    // Flush at latency 1 with two buffered and one in flight
    mready1 = 1'b0;
    put1(8'hB0); put1(8'hB1); put1(8'hB2); put1(8'hB3);
    tick; tick; tick;
    chk("e_occ", 32'(occ1), 32'd2);
    chk("e_data", 32'(mdata1), 32'hB0);
    chk("e_rinc", 32'(rinc1), 32'd0);
    flush1 = 1'b1;
    tick;
    chk("e_valid_fl", 32'(mvalid1), 32'd0);
    chk("e_occ_fl", 32'(occ1), 32'd0);
    flush1 = 1'b0;
    #1;
    chk("e_rinc_after", 32'(rinc1), 32'd1);
    tick;
    chk("e_no_stale", 32'(mvalid1), 32'd0);
    tick;
    chk("e_valid_b3", 32'(mvalid1), 32'd1);
    chk("e_data_b3", 32'(mdata1), 32'hB3);
    mready1 = 1'b1;
    tick;
    chk("e_valid_end", 32'(mvalid1), 32'd0);
    chk("e_cnt", 32'(cnt1), 32'd11);

    // Counter wrap: 17th pop on a 4-bit counter
    for (int i = 0; i < 9; i++) put0(8'h70 + 8'(i));
    for (int k = 0; k < 9; k++) begin
      tick;
      chk("f_data", 32'(mdata0), 32'h70 + 32'(k));
    end
    tick;
    chk("f_valid_end", 32'(mvalid0), 32'd0);
    chk("f_cnt_wrap", 32'(cnt0), 32'd1);

    // Async reset mid-stream with the clock stopped
    for (int i = 0; i < 5; i++) put1(8'hC0 + 8'(i));
    tick; tick; tick;
    chk("g_data_pre", 32'(mdata1), 32'hC1);
    @(negedge clk);
    run = 1'b0;
    #2;
    rrst_n = 1'b0;
    #1;
    chk("g_rst_valid", 32'(mvalid1), 32'd0);
    chk("g_rst_data", 32'(mdata1), 32'd0);
    chk("g_rst_occ", 32'(occ1), 32'd0);
    chk("g_rst_cnt", 32'(cnt1), 32'd0);
    chk("g_rst_rinc", 32'(rinc1), 32'd0);
    chk("g_rst_cnt0", 32'(cnt0), 32'd0);
    #1;
    rrst_n = 1'b1;
    #1;
    chk("g_rinc_rel", 32'(rinc1), 32'd1);
    run = 1'b1;
    tick;
    chk("g_no_late", 32'(mvalid1), 32'd0);
    tick;
    chk("g_valid_c3", 32'(mvalid1), 32'd1);
    chk("g_data_c3", 32'(mdata1), 32'hC3);
    tick;
    chk("g_data_c4", 32'(mdata1), 32'hC4);
    tick;
    chk("g_valid_end", 32'(mvalid1), 32'd0);
    chk("g_cnt", 32'(cnt1), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/afifo_rd_stream.md
AFIFO_RD_STREAM -- requirements
Module: afifo_rd_stream

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data word width, equal to the FIFO DSIZE.
REQ-002 SHALL have parameter RD_LATENCY, default 0: FIFO read latency; 0 = fifo_rdata shows the head word whenever fifo_rempty=0, 1 = word appears on fifo_rdata one rclk after fifo_rinc.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the word counter.
REQ-004 SHALL have one clock and asynchronous active-low reset: rclk and rrst_n.
REQ-005 Port rclk, input, 1: read-domain clock.
REQ-006 Port rrst_n, input, 1: asynchronous active-low reset.
REQ-007 Port fifo_rdata, input, DSIZE: FIFO read data.
REQ-008 Port fifo_rempty, input, 1: FIFO empty flag, registered in the rclk domain.
REQ-009 Port fifo_rinc, output, 1: FIFO read-increment strobe.
REQ-010 Port flush, input, 1: synchronous discard of all buffered and in-flight words.
REQ-011 Port m_data, output, DSIZE: stream data.
REQ-012 Port m_valid, output, 1: stream valid.
REQ-013 Port m_ready, input, 1: stream ready.
REQ-014 Port occupancy, output, 2: number of words held in the skid buffer (0..BUF_DEPTH).
REQ-015 Port word_cnt, output, CNT_WIDTH: count of words accepted downstream.

Function
REQ-016 SHALL hold words in an internal FIFO-ordered skid buffer of depth BUF_DEPTH = 2 + RD_LATENCY.
REQ-017 SHALL drive m_data from the buffer head register and m_valid = (occupancy != 0), both from registers only.
REQ-018 SHALL transfer a word on each rclk edge where m_valid=1 and m_ready=1 (pop).
REQ-019 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-020 SHALL track in-flight reads (0..RD_LATENCY) issued but not yet captured.
REQ-021 SHALL assert fifo_rinc = !fifo_rempty && !flush && (occupancy + inflight) < BUF_DEPTH.
REQ-022 fifo_rinc SHALL NOT depend combinationally on m_ready.
REQ-023 SHALL never assert fifo_rinc while fifo_rempty=1.
REQ-024 RD_LATENCY=0: SHALL capture fifo_rdata into the buffer on the same edge that samples fifo_rinc=1.
REQ-025 RD_LATENCY=1: SHALL capture fifo_rdata on the edge one cycle after the edge that samples fifo_rinc=1.
REQ-026 SHALL sustain one word per cycle when the FIFO is non-empty and m_ready=1 continuously; first-word latency from fifo_rempty falling to m_valid=1 SHALL be 1 + RD_LATENCY cycles.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-028 Push into a buffer with occupancy BUF_DEPTH SHALL be impossible by construction; an implementation assertion SHALL flag it.
REQ-029 flush=1 on an edge SHALL set occupancy to 0 and m_valid to 0, and SHALL discard any in-flight word arriving on that edge or the following RD_LATENCY edges; the FIFO pointer is not rewound.
REQ-030 A pop coinciding with flush SHALL still count in word_cnt.
REQ-031 word_cnt SHALL increment by 1 per pop, wrap modulo 2^CNT_WIDTH, and be unaffected by flush.

Reset
REQ-032 While rrst_n=0: occupancy=0, m_valid=0, m_data=0, word_cnt=0, in-flight=0, fifo_rinc=0, regardless of fifo_rempty.
REQ-033 Reset assertion SHALL take effect asynchronously; release SHALL be synchronous to rclk. The first fifo_rinc SHALL be possible in the first cycle after release.
REQ-034 Reset mid-transfer SHALL drop all buffered and in-flight words with no late capture after release.

Verification
REQ-035 RD_LATENCY=0, FIFO holds 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, word_cnt=3, fifo_rinc exactly 3 cycles high.
REQ-036 RD_LATENCY=1, 10 words, m_ready=1 after first valid -> 10 words in order, back-to-back after the first, first m_valid 2 cycles after fifo_rempty falls.
REQ-037 m_ready=0 with FIFO non-empty -> occupancy saturates at BUF_DEPTH, fifo_rinc low, m_data frozen; on m_ready=1 order is intact with no duplicate or lost word.
REQ-038 RD_LATENCY=1, flush pulsed with occupancy=2 and 1 in flight -> m_valid=0 next cycle, the in-flight word is discarded, and the next FIFO word is delivered after flush drops.
REQ-039 CNT_WIDTH=4, 17 pops -> word_cnt=1 (wrap).
REQ-040 rrst_n pulsed low during streaming with rclk stopped -> outputs zero immediately; after release, no stale word appears.
